// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, drives the synchronous instruction
// memory and feeds the FD latch. Optional perf counters under FETCH_PERF_EN.
//
// state  | meaning
// BOOT   | after reset; data from memory not yet valid, emit bubble
// RUN    | imem_q holds the instruction at last_pc, deliver it
// SQUASH | redirect target being fetched, emit bubble
module fetch_stage #(
    parameter int          ADDR_W   = 12,
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] NOP      = 32'd0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_q,
    output logic [31:0]       out_IR,
    output logic [31:0]       out_PC_next,
    output logic              fd_wren,
    output logic [31:0]       fetch_count,
    output logic [31:0]       squash_count
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        SQUASH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] last_pc_q, last_pc_d;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC;
            last_pc_q <= RESET_PC;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            last_pc_q <= last_pc_d;
        end
    end

    // Redirect wins over stall; the stale in-flight word is dropped via SQUASH.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        last_pc_d = last_pc_q;
        if (redirect) begin
            pc_d    = redirect_pc;
            state_d = SQUASH;
        end else if (!stall) begin
            last_pc_d = pc_q;
            pc_d      = pc_q + 32'd1;
            state_d   = RUN;
        end
    end

    always_comb begin
        imem_addr   = pc_q[ADDR_W-1:0];
        out_IR      = NOP;
        out_PC_next = 32'd0;
        fd_wren     = 1'b0;
        if (!reset) begin
            imem_addr = RESET_PC[ADDR_W-1:0];
        end else begin
            fd_wren = !stall || redirect;
            if (state_q == RUN && !redirect) begin
                out_IR      = imem_q;
                out_PC_next = last_pc_q + 32'd1;
                // Re-issue the held address so imem_q keeps the same word.
                if (stall) begin
                    imem_addr = last_pc_q[ADDR_W-1:0];
                end
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] squash_cnt_q, squash_cnt_d;

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        squash_cnt_d = squash_cnt_q;
        if (fd_wren && state_q == RUN && !redirect) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (redirect || (state_q == SQUASH && !stall)) begin
            squash_cnt_d = squash_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            fetch_cnt_q  <= 32'd0;
            squash_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign fetch_count  = fetch_cnt_q;
    assign squash_count = squash_cnt_q;
`else
    assign fetch_count  = 32'd0;
    assign squash_count = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: instruction memory returns A000_0000 + address
// one cycle after the address is issued.
module tb_fetch_stage;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [11:0] imem_addr;
    logic [31:0] imem_q;
    logic [31:0] out_IR;
    logic [31:0] out_PC_next;
    logic        fd_wren;
    logic [31:0] fetch_count;
    logic [31:0] squash_count;

    int checks = 0;
    int errors = 0;

`ifdef FETCH_PERF_EN
    localparam logic [31:0] FC_AT_C13 = 32'd7;
    localparam logic [31:0] SC_AT_C13 = 32'd2;
    localparam logic [31:0] SC_AT_C16 = 32'd4;
    localparam logic [31:0] FC_AT_C21 = 32'd11;
    localparam logic [31:0] SC_AT_C21 = 32'd6;
`else
    localparam logic [31:0] FC_AT_C13 = 32'd0;
    localparam logic [31:0] SC_AT_C13 = 32'd0;
    localparam logic [31:0] SC_AT_C16 = 32'd0;
    localparam logic [31:0] FC_AT_C21 = 32'd0;
    localparam logic [31:0] SC_AT_C21 = 32'd0;
`endif

    fetch_stage #(
        .ADDR_W  (12),
        .RESET_PC(32'd0),
        .NOP     (32'd0)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_q      (imem_q),
        .out_IR      (out_IR),
        .out_PC_next (out_PC_next),
        .fd_wren     (fd_wren),
        .fetch_count (fetch_count),
        .squash_count(squash_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial imem_q = 32'd0;
    always @(posedge clock) imem_q <= 32'hA000_0000 + {20'd0, imem_addr};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] ir, input logic [31:0] pcn,
                           input logic wren, input logic [11:0] addr);
        chk({tag, ".ir"}, out_IR, ir);
        chk({tag, ".pcn"}, out_PC_next, pcn);
        chk({tag, ".wren"}, {31'd0, fd_wren}, {31'd0, wren});
        chk({tag, ".addr"}, {20'd0, imem_addr}, {20'd0, addr});
    endtask

    task automatic cyc(input logic rst, input logic st, input logic rd, input logic [31:0] rpc);
        @(negedge clock);
        reset       = rst;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;

        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        chk_out("reset", 32'd0, 32'd0, 1'b0, 12'd0);
        chk("reset.fc", fetch_count, 32'd0);
        chk("reset.sc", squash_count, 32'd0);

        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        chk_out("boot", 32'd0, 32'd0, 1'b1, 12'd0);
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        chk_out("run1", 32'hA000_0000, 32'd1, 1'b1, 12'd1);
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        chk_out("run2", 32'hA000_0001, 32'd2, 1'b1, 12'd2);
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        chk_out("run3", 32'hA000_0002, 32'd3, 1'b1, 12'd3);
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        chk_out("run4", 32'hA000_0003, 32'd4, 1'b1, 12'd4);
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        chk_out("run5", 32'hA000_0004, 32'd5, 1'b1, 12'd5);

        cyc(1'b1, 1'b1, 1'b0, 32'd0);
        chk_out("stall1", 32'hA000_0005, 32'd6, 1'b0, 12'd5);
        cyc(1'b1, 1'b1, 1'b0, 32'd0);
        chk_out("stall2", 32'hA000_0005, 32'd6, 1'b0, 12'd5);
        cyc(1'b1, 1'b1, 1'b0, 32'd0);
        chk_out("stall3", 32'hA000_0005, 32'd6, 1'b0, 12'd5);
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        chk_out("unstall", 32'hA000_0005, 32'd6, 1'b1, 12'd6);
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        chk_out("after_stall", 32'hA000_0006, 32'd7, 1'b1, 12'd7);

        cyc(1'b1, 1'b0, 1'b1, 32'd40);
        chk("redir.ir", out_IR, 32'd0);
        chk("redir.pcn", out_PC_next, 32'd0);
        chk("redir.wren", {31'd0, fd_wren}, 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        chk_out("squash", 32'd0, 32'd0, 1'b1, 12'd40);
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        chk_out("target", 32'hA000_0028, 32'd41, 1'b1, 12'd41);
        chk("target.fc", fetch_count, FC_AT_C13);
        chk("target.sc", squash_count, SC_AT_C13);

        cyc(1'b1, 1'b1, 1'b1, 32'd100);
        chk("stredir.ir", out_IR, 32'd0);
        chk("stredir.pcn", out_PC_next, 32'd0);
        chk("stredir.wren", {31'd0, fd_wren}, 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        chk_out("stredir.sq", 32'd0, 32'd0, 1'b1, 12'd100);
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        chk_out("stredir.tgt", 32'hA000_0064, 32'd101, 1'b1, 12'd101);
        chk("stredir.sc", squash_count, SC_AT_C16);

        cyc(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
        chk("wrap.redir.ir", out_IR, 32'd0);
        chk("wrap.redir.wren", {31'd0, fd_wren}, 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        chk_out("wrap.sq", 32'd0, 32'd0, 1'b1, 12'hFFF);
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        chk_out("wrap.tgt", 32'hA000_0FFF, 32'd0, 1'b1, 12'd0);
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        chk_out("wrap.next", 32'hA000_0000, 32'd1, 1'b1, 12'd1);
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        chk_out("wrap.next2", 32'hA000_0001, 32'd2, 1'b1, 12'd2);
        chk("pre_rst.fc", fetch_count, FC_AT_C21);
        chk("pre_rst.sc", squash_count, SC_AT_C21);

        cyc(1'b0, 1'b0, 1'b1, 32'd55);
        chk_out("midrst", 32'd0, 32'd0, 1'b0, 12'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        chk_out("midrst2", 32'd0, 32'd0, 1'b0, 12'd0);
        chk("midrst.fc", fetch_count, 32'd0);
        chk("midrst.sc", squash_count, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        chk_out("reboot", 32'd0, 32'd0, 1'b1, 12'd0);
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        chk_out("rerun1", 32'hA000_0000, 32'd1, 1'b1, 12'd1);
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        chk_out("rerun2", 32'hA000_0001, 32'd2, 1'b1, 12'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
